// File: rtl/vga_pkg.sv
// Shared scancode constants and a parity helper for the keyboard front end.
// The optional odd-parity check is enabled by defining PS2_PARITY_CHECK_EN.
package vga_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned KEYCODE_W = 2 * BYTE_W;

  localparam logic [BYTE_W-1:0] KEY_BREAK = 8'hF0;
  localparam logic [BYTE_W-1:0] KEY_ENTER = 8'h5A;
  localparam logic [BYTE_W-1:0] KEY_R     = 8'h2D;

  // True when the data byte plus its parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 lines plus a falling-edge strobe on the synced clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_c,
  output logic data_sync
);

  logic clk_meta;
  logic clk_sync;
  logic clk_prev;
  logic data_meta;

  // Lines idle high, so every stage resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall_c = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard frame receiver presenting {previous byte, latest byte}.
// Define PS2_PARITY_CHECK_EN to discard frames failing odd parity.
module ps2_keycode_rx
  import vga_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [KEYCODE_W-1:0] keycode,
  output logic                 keycode_valid,
  output logic                 frame_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W = $clog2(BYTE_W);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [BYTE_W-1:0]   shift;
  logic                parity_bit;
  logic [TMO_W-1:0]    tmo;
  logic                fall_c;
  logic                data_s;
  logic                parity_ok_c;

  ps2_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fall_c    (fall_c),
    .data_sync (data_s)
  );

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok_c = odd_parity_ok(shift, parity_bit);
`else
  // Parity is still captured so a later build can inspect it; it never rejects a frame here.
  assign parity_ok_c = parity_bit | 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      parity_bit    <= 1'b0;
      tmo           <= '0;
      keycode       <= '0;
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;

      // Inter-edge watchdog: only runs while a frame is in progress.
      if (state == IDLE || fall_c) begin
        tmo <= '0;
      end else if (tmo != TMO_MAX) begin
        tmo <= TMO_W'(tmo + 1'b1);
      end

      // A stalled frame is abandoned; returning to IDLE clears tmo so this fires once.
      if (state != IDLE && tmo == TMO_MAX) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        shift     <= '0;
        frame_err <= 1'b1;
      end else if (fall_c) begin
        unique case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {data_s, shift[BYTE_W-1:1]};
            bit_cnt <= CNT_W'(bit_cnt + 1'b1);
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_bit <= data_s;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_s && parity_ok_c) begin
              keycode       <= {keycode[BYTE_W-1:0], shift};
              keycode_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: directed scenarios plus random frames
// checked against a byte-level model of the keycode register.
module tb_ps2_keycode_rx;
  import vga_pkg::*;

  localparam int unsigned TMO  = 300;
  localparam int unsigned HALF = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        keycode_valid;
  logic        frame_err;

  int n_chk = 0;
  int n_pass = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  logic [15:0] model_kc = 16'h0000;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
`else
  localparam bit PAR_CHECK = 1'b0;
`endif

  ps2_keycode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .keycode       (keycode),
    .keycode_valid (keycode_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (keycode_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
    if (keycode_valid === 1'b1 && frame_err === 1'b1) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the low n bits of a frame, LSB first, data set up while ps2_clk is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Send one frame, update the model from the frame rules and check the result.
  task automatic do_frame(input string tag, input logic [7:0] b, input logic par, input logic stop);
    int v0, e0;
    bit good;
    v0 = n_valid;
    e0 = n_err;
    send_bits({stop, par, b, 1'b0}, 11);
    wait_cycles(8);
    good = stop && (!PAR_CHECK || ($countones({b, par}) % 2 == 1));
    if (good) model_kc = {model_kc[7:0], b};
    check({tag, "_kc"}, 32'(keycode), 32'(model_kc));
    check({tag, "_valid"}, 32'(n_valid - v0), good ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(n_err - e0), good ? 32'd0 : 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    model_kc = 16'h0000;
    wait_cycles(3);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  initial begin
    int e0, v0;
    logic [7:0] b;
    logic par, stop;

    wait_cycles(4);
    check("rst_kc", 32'(keycode), 32'h0);
    check("rst_valid", 32'(keycode_valid), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    wait_cycles(4);

    do_frame("enter", KEY_ENTER, 1'b1, 1'b1);
    check("enter_abs", 32'(keycode), 32'h005A);

    do_reset();
    do_frame("brk", KEY_BREAK, odd_par(KEY_BREAK), 1'b1);
    check("brk_abs", 32'(keycode), 32'h00F0);
    do_frame("brk_enter", KEY_ENTER, 1'b1, 1'b1);
    check("brk_enter_abs", 32'(keycode), 32'hF05A);

    do_frame("stop0", KEY_R, odd_par(KEY_R), 1'b0);
    check("stop0_abs", 32'(keycode), 32'hF05A);

    // Start bit plus four data bits, then silence past the timeout.
    e0 = n_err;
    v0 = n_valid;
    send_bits({3'b111, KEY_R, 1'b0}, 5);
    wait_cycles(2 * TMO);
    check("tmo_err", 32'(n_err - e0), 32'd1);
    check("tmo_valid", 32'(n_valid - v0), 32'd0);
    do_frame("after_tmo", KEY_R, odd_par(KEY_R), 1'b1);
    check("after_tmo_lo", 32'(keycode[7:0]), 32'h2D);

    do_frame("bad_par", KEY_ENTER, 1'b0, 1'b1);

    // Reset lands after the fifth data bit of a frame.
    e0 = n_err;
    send_bits({3'b111, KEY_ENTER, 1'b0}, 6);
    do_reset();
    wait_cycles(20);
    check("midrst_kc", 32'(keycode), 32'h0);
    check("midrst_err", 32'(n_err - e0), 32'd0);
    do_frame("post_rst", KEY_ENTER, 1'b1, 1'b1);
    check("post_rst_abs", 32'(keycode), 32'h005A);

    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      par = ($urandom_range(0, 5) == 0) ? ~odd_par(b) : odd_par(b);
      stop = ($urandom_range(0, 6) != 0);
      do_frame($sformatf("rnd%0d", i), b, par, stop);
      wait_cycles($urandom_range(1, 60));
    end

    check("excl", 32'(n_both), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
